matrix_capture: RTL
===================

Name: matrix_capture

Overview:
- Receiving end of the row-scanned 8x8 matrix interface driven by the display scanner.
- Samples the row-select, column-data and frame-done lines, checks the scan sequence, and rebuilds the full GS x GS frame into a shadow buffer.
- On a clean frame, publishes the buffer on matrix_o with a one-cycle valid pulse.
- Used for loopback self-test on the chip and as a bench monitor. Bit order matches the transmitter: matrix bit GS*r + c = column c of row r.

Parameters:
GS, 8, grid size (rows = columns = GS)
SETTLE, 2, consecutive stable synchronized cycles required before a row is captured (1..15)

Ports:
clk_i  input  1  system clock
rst_ni  input  1  asynchronous active-low reset
en_i  input  1  capture enable; low forces IDLE, matrix_o holds
row_val_i  input  GS  active-low one-hot row select from scanner
col_val_i  input  GS  column data for the selected row
d_disp_i  input  1  frame-done strobe from scanner
matrix_o  output  GS*GS  last complete frame
frame_valid_o  output  1  one-cycle pulse when matrix_o is updated
frame_err_o  output  1  one-cycle pulse when a frame is aborted on a protocol violation
row_idx_o  output  $clog2(GS+1)  next expected row index (debug)

Behaviour:
- Reset (rst_ni low, asynchronous): matrix_o=0, frame_valid_o=0, frame_err_o=0, row_idx_o=0, shadow buffer=0, all synchronizer flops=1 (row), 0 (col, d_disp), state=IDLE.
- Synchronizers: row_val_i, col_val_i and d_disp_i each pass through 2 flops; all logic uses the synchronized copies.
- d_disp is rising-edge detected on the synchronized copy. A strobe held high for several cycles counts once.
- P(r) = all ones except bit r = 0. "Blank" = row all-zero or all-ones (scanner disabled or between frames).
- States:
  - IDLE: row_idx=0. Go to SETTLE when row == P(0).
  - SETTLE: a stable counter increments while row and col equal their previous-cycle values; any change resets it to 0. When the count reaches SETTLE with row == P(row_idx): write col into shadow row row_idx, increment row_idx, go to HOLD. If row becomes Blank: go to IDLE, no error. Any other row value: error.
  - HOLD: row unchanged -> stay. Row == P(row_idx) with row_idx<GS -> SETTLE. d_disp edge with row_idx==GS -> commit. Blank -> IDLE, no error. Any other row value, or a d_disp edge with row_idx<GS -> error.
- Commit: matrix_o <= shadow (whole frame in one cycle); frame_valid_o=1 for exactly 1 cycle; next state IDLE. This is the only path that updates matrix_o.
- Error: frame_err_o=1 for 1 cycle; shadow is kept but not published; state IDLE, row_idx=0.
- Latency: d_disp_i rising, sampled at edge N -> frame_valid_o high during the cycle after edge N+3, then low.
- A row re-captured within the same frame (scanner repeats a row) is impossible by construction: HOLD accepts only P(row_idx) as the next row.
- en_i low at any time: next cycle state=IDLE, row_idx=0, no pulses; matrix_o retains its value. Synchronizers keep running.
- Reset asserted mid-frame: immediate return to reset values; the partial frame is lost.
- Simultaneous d_disp edge and row change in HOLD: the d_disp rule has priority.
- Width rules: row_idx saturates at GS; the stable counter saturates at SETTLE.

Test Plan:
- Scan rows 0..7 with col = 8'hA5 ^ r, each row held 100 cycles, then a 1-cycle d_disp -> one frame_valid_o pulse; matrix_o row r = 8'hA5^r, i.e. matrix_o[7:0]=8'hA5, matrix_o[63:56]=8'hA2; frame_err_o never high.
- Same scan with rows 0,1,3 (row 2 skipped) -> frame_err_o pulse when P(3) appears; matrix_o keeps its previous value; no frame_valid_o.
- d_disp pulse after only 5 rows captured -> frame_err_o pulse; row_idx_o returns to 0.
- row_val_i = 8'hF6 (two rows active) in SETTLE -> frame_err_o pulse. row_val_i = 8'h00 mid-frame -> silent return to IDLE, no pulses.
- Column data toggling every cycle during row 4 for 50 cycles, then stable at 8'h3C -> shadow row 4 = 8'h3C after SETTLE stable cycles; commit shows matrix_o[39:32]=8'h3C.
- Drop en_i for 1 cycle at row 6, or assert rst_ni low mid-frame -> no frame_valid_o for that frame. After rst_ni, matrix_o=0; the next full scan commits normally.

Source files
------------

// File: rtl/matrix_capture.sv
// Receiver for the row-scanned GS x GS matrix link: synchronizes the scan
// lines, checks the row sequence and publishes each clean frame at once.
module matrix_capture #(
    parameter int GS     = 8,
    parameter int SETTLE = 2
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   en_i,
    input  logic [GS-1:0]          row_val_i,
    input  logic [GS-1:0]          col_val_i,
    input  logic                   d_disp_i,
    output logic [GS*GS-1:0]       matrix_o,
    output logic                   frame_valid_o,
    output logic                   frame_err_o,
    output logic [$clog2(GS+1)-1:0] row_idx_o
);

    localparam int IW = $clog2(GS + 1);
    localparam int CW = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_HOLD
    } state_t;

    state_t            state_q, state_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [GS-1:0]     row_s1, row_s2, row_q;
    logic [GS-1:0]     col_s1, col_s2, col_q;
    logic              d_s1, d_s2, d_s3, d_edge;
    logic [GS*GS-1:0]  shadow_q, matrix_q;
    logic              valid_q, err_q;
    logic              cap, commit, err;
    logic              stable, blank, full;
    logic [GS-1:0]     exp_row, row0;

    // Active-low one-hot pattern; indices >= GS yield all ones (blank)
    function automatic logic [GS-1:0] pat(input logic [IW-1:0] i);
        return ~({{(GS-1){1'b0}}, 1'b1} << i);
    endfunction

    assign stable  = (row_s2 == row_q) && (col_s2 == col_q);
    assign blank   = (row_s2 == '0) || (row_s2 == '1);
    assign full    = (idx_q == IW'(GS));
    assign exp_row = pat(idx_q);
    assign row0    = pat('0);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = '0;
        cap     = 1'b0;
        commit  = 1'b0;
        err     = 1'b0;
        if (!en_i) begin
            state_d = ST_IDLE;
            idx_d   = '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    idx_d = '0;
                    if (row_s2 == row0) state_d = ST_SETTLE;
                end
                ST_SETTLE: begin
                    if (stable)
                        cnt_d = (cnt_q >= CW'(SETTLE)) ? CW'(SETTLE) : cnt_q + 1'b1;
                    if (blank) begin
                        state_d = ST_IDLE;
                        idx_d   = '0;
                    end else if (row_s2 != exp_row) begin
                        err = 1'b1;
                    end else if (cnt_d == CW'(SETTLE)) begin
                        cap     = 1'b1;
                        idx_d   = full ? idx_q : idx_q + 1'b1;
                        state_d = ST_HOLD;
                        cnt_d   = '0;
                    end
                end
                ST_HOLD: begin
                    // Frame-done outranks any row change in the same cycle
                    if (d_edge) begin
                        if (full) commit = 1'b1;
                        else      err    = 1'b1;
                    end else if (row_s2 == row_q) begin
                        state_d = ST_HOLD;
                    end else if (!full && row_s2 == exp_row) begin
                        state_d = ST_SETTLE;
                    end else if (blank) begin
                        state_d = ST_IDLE;
                        idx_d   = '0;
                    end else begin
                        err = 1'b1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    idx_d   = '0;
                end
            endcase
            if (err || commit) begin
                state_d = ST_IDLE;
                idx_d   = '0;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            row_s1   <= '1;
            row_s2   <= '1;
            row_q    <= '1;
            col_s1   <= '0;
            col_s2   <= '0;
            col_q    <= '0;
            d_s1     <= 1'b0;
            d_s2     <= 1'b0;
            d_s3     <= 1'b0;
            d_edge   <= 1'b0;
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            cnt_q    <= '0;
            shadow_q <= '0;
            matrix_q <= '0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            row_s1  <= row_val_i;
            row_s2  <= row_s1;
            row_q   <= row_s2;
            col_s1  <= col_val_i;
            col_s2  <= col_s1;
            col_q   <= col_s2;
            d_s1    <= d_disp_i;
            d_s2    <= d_s1;
            d_s3    <= d_s2;
            d_edge  <= d_s2 & ~d_s3;
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            for (int r = 0; r < GS; r++)
                if (cap && int'(idx_q) == r)
                    shadow_q[r*GS +: GS] <= col_s2;
            if (commit) matrix_q <= shadow_q;
            valid_q <= commit;
            err_q   <= err;
        end
    end

    assign matrix_o      = matrix_q;
    assign frame_valid_o = valid_q;
    assign frame_err_o   = err_q;
    assign row_idx_o     = idx_q;

endmodule
